reorder_buffer: RTL and testbench

- Circular reorder buffer that sits beside the rename stage.
- Hands out physical-register tags to rename (next_free/is_free/do_alloc) and records the arch destination and PC of each dispatched instruction.
- Captures execution writebacks by tag and retires entries in program order through the commit_* interface, which rename consumes to update its ARF and RAT.
- Also serves operand-value lookups by tag.

---
 rtl/rob_pkg.sv | 37 +++
 rtl/rob_ptr.sv | 29 ++
 rtl/reorder_buffer.sv | 185 ++++++++++++++++++
 tb/tb_reorder_buffer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer slice.
// Holds the datapath widths, the entry record layout and the tag helpers
// used by the top level to map physical tags onto entry indices.
package rob_pkg;

   localparam int ARCH_W  = 5;
   localparam int TAG_W   = 8;
   localparam int DATA_W  = 64;
   localparam int PC_W    = 64;
   localparam int FLAGS_W = 13;

   // One reorder buffer slot: bookkeeping bits plus the captured payload.
   typedef struct packed {
      logic               valid;
      logic               done;
      logic [ARCH_W-1:0]  arf;
      logic [PC_W-1:0]    pc;
      logic [DATA_W-1:0]  result;
      logic [FLAGS_W-1:0] flags;
   } rob_entry_t;

   // True when the tag names one of the DEPTH entries starting at base.
   function automatic logic tag_in_range(input logic [TAG_W-1:0] tag,
                                         input int base,
                                         input int depth);
      int t;
      t = int'(tag);
      return (t >= base) && (t < base + depth);
   endfunction

   // Offset of the tag from the first entry; callers keep the low index bits.
   function automatic logic [TAG_W-1:0] tag_to_idx(input logic [TAG_W-1:0] tag,
                                                   input logic [TAG_W-1:0] base);
      return tag - base;
   endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrapping pointer register used for the reorder buffer head and tail.
// Ports:
//   clock   - rising-edge clock
//   reset_n - asynchronous active-low reset, pointer goes to 0
//   clear   - synchronous clear, wins over inc
//   inc     - advance the pointer by one, wrapping modulo 2**W
//   ptr     - current pointer value
module rob_ptr #(
   parameter int W = 5
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] ptr
);

   // Natural overflow of the W-bit register provides the modulo-DEPTH wrap.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (clear) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + W'(1);
      end
   end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer beside the rename stage.
// Hands out physical tags at the tail, captures writebacks by tag, retires
// entries in program order from the head and serves two operand lookups.
// Ports:
//   clock, reset_n                     - clock and async active-low reset
//   do_alloc, alloc_arf, alloc_pc      - allocate the tail entry
//   next_free, is_free                 - tag of the tail entry / space left
//   wb_valid, wb_tag, wb_result, wb_flags - execution writeback
//   rd1_*/rd2_*                        - combinational operand lookups
//   flush                              - discard every in-flight entry
//   commit_*                           - registered in-order retirement
module reorder_buffer
   import rob_pkg::*;
#(
   parameter  int DEPTH    = 32,
   parameter  int TAG_BASE = 32,
   localparam int IDX_W    = $clog2(DEPTH)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               do_alloc,
   input  logic [ARCH_W-1:0]  alloc_arf,
   input  logic [PC_W-1:0]    alloc_pc,
   output logic [TAG_W-1:0]   next_free,
   output logic               is_free,
   input  logic               wb_valid,
   input  logic [TAG_W-1:0]   wb_tag,
   input  logic [DATA_W-1:0]  wb_result,
   input  logic [FLAGS_W-1:0] wb_flags,
   input  logic [TAG_W-1:0]   rd1_tag,
   output logic [DATA_W-1:0]  rd1_data,
   output logic               rd1_ready,
   input  logic [TAG_W-1:0]   rd2_tag,
   output logic [DATA_W-1:0]  rd2_data,
   output logic               rd2_ready,
   input  logic               flush,
   output logic [ARCH_W-1:0]  commit_arf,
   output logic [DATA_W-1:0]  commit_result,
   output logic [PC_W-1:0]    commit_pc,
   output logic [FLAGS_W-1:0] commit_flags,
   output logic               commit_valid
);

   localparam logic [IDX_W:0]   FULL_COUNT = (IDX_W+1)'(DEPTH);
   localparam logic [TAG_W-1:0] BASE_TAG   = TAG_W'(TAG_BASE);

   logic [IDX_W-1:0]   head;
   logic [IDX_W-1:0]   tail;
   logic [IDX_W:0]     count_q;
   logic [DEPTH-1:0]   valid_q;
   logic [DEPTH-1:0]   done_q;
   logic [ARCH_W-1:0]  arf_q    [DEPTH];
   logic [PC_W-1:0]    pc_q     [DEPTH];
   logic [DATA_W-1:0]  result_q [DEPTH];
   logic [FLAGS_W-1:0] flags_q  [DEPTH];

   rob_entry_t         head_entry;
   logic [IDX_W-1:0]   wb_idx;
   logic [IDX_W-1:0]   rd1_idx;
   logic [IDX_W-1:0]   rd2_idx;
   logic               rd1_hit;
   logic               rd2_hit;
   logic               alloc_fire;
   logic               wb_fire;
   logic               commit_fire;

   assign is_free   = (count_q != FULL_COUNT);
   assign next_free = BASE_TAG + TAG_W'(tail);

   // Flush suppresses every other update in its cycle, so it gates all fires.
   // The slot at the tail is always invalid unless the buffer is full, so an
   // allocation and a writeback never target the same entry.
   always_comb begin
      wb_idx      = IDX_W'(tag_to_idx(wb_tag, BASE_TAG));
      alloc_fire  = do_alloc && is_free && !flush;
      wb_fire     = wb_valid && tag_in_range(wb_tag, TAG_BASE, DEPTH)
                    && valid_q[wb_idx] && !flush;
      head_entry.valid  = valid_q[head];
      head_entry.done   = done_q[head];
      head_entry.arf    = arf_q[head];
      head_entry.pc     = pc_q[head];
      head_entry.result = result_q[head];
      head_entry.flags  = flags_q[head];
      commit_fire = (count_q != '0) && head_entry.valid && head_entry.done
                    && !flush;
   end

   rob_ptr #(.W(IDX_W)) u_head_ptr (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (flush),
      .inc     (commit_fire),
      .ptr     (head)
   );

   rob_ptr #(.W(IDX_W)) u_tail_ptr (
      .clock   (clock),
      .reset_n (reset_n),
      .clear   (flush),
      .inc     (alloc_fire),
      .ptr     (tail)
   );

   // Bookkeeping bits. A writeback landing on the entry that retires on the
   // same edge is harmless: the later commit assignment clears the slot.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         done_q  <= '0;
      end else if (flush) begin
         valid_q <= '0;
         done_q  <= '0;
      end else begin
         if (alloc_fire) begin
            valid_q[tail] <= 1'b1;
            done_q[tail]  <= 1'b0;
         end
         if (wb_fire) begin
            done_q[wb_idx] <= 1'b1;
         end
         if (commit_fire) begin
            valid_q[head] <= 1'b0;
            done_q[head]  <= 1'b0;
         end
      end
   end

   // Payload storage is never reset; the valid bits make stale data invisible.
   always_ff @(posedge clock) begin
      if (alloc_fire) begin
         arf_q[tail] <= alloc_arf;
         pc_q[tail]  <= alloc_pc;
      end
      if (wb_fire) begin
         result_q[wb_idx] <= wb_result;
         flags_q[wb_idx]  <= wb_flags;
      end
   end

   // Occupancy tracks net allocations minus retirements.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (flush) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
      end
   end

   // Registered retirement port; payload fields hold between commits.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         commit_valid  <= 1'b0;
         commit_arf    <= '0;
         commit_result <= '0;
         commit_pc     <= '0;
         commit_flags  <= '0;
      end else if (flush) begin
         commit_valid <= 1'b0;
      end else begin
         commit_valid <= commit_fire;
         if (commit_fire) begin
            commit_arf    <= head_entry.arf;
            commit_result <= head_entry.result;
            commit_pc     <= head_entry.pc;
            commit_flags  <= head_entry.flags;
         end
      end
   end

   // Operand lookups see only captured state; same-cycle writebacks are not
   // forwarded.
   always_comb begin
      rd1_idx   = IDX_W'(tag_to_idx(rd1_tag, BASE_TAG));
      rd2_idx   = IDX_W'(tag_to_idx(rd2_tag, BASE_TAG));
      rd1_hit   = tag_in_range(rd1_tag, TAG_BASE, DEPTH);
      rd2_hit   = tag_in_range(rd2_tag, TAG_BASE, DEPTH);
      rd1_ready = rd1_hit && valid_q[rd1_idx] && done_q[rd1_idx];
      rd2_ready = rd2_hit && valid_q[rd2_idx] && done_q[rd2_idx];
      rd1_data  = rd1_hit ? result_q[rd1_idx] : '0;
      rd2_data  = rd2_hit ? result_q[rd2_idx] : '0;
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer (DEPTH=32, TAG_BASE=32).
// Directed stimulus pushes the expected retirements into a scoreboard queue;
// a negedge monitor pops and compares every commit the DUT presents.
module tb_reorder_buffer;

   logic        clock;
   logic        reset_n;
   logic        do_alloc;
   logic [4:0]  alloc_arf;
   logic [63:0] alloc_pc;
   logic [7:0]  next_free;
   logic        is_free;
   logic        wb_valid;
   logic [7:0]  wb_tag;
   logic [63:0] wb_result;
   logic [12:0] wb_flags;
   logic [7:0]  rd1_tag;
   logic [63:0] rd1_data;
   logic        rd1_ready;
   logic [7:0]  rd2_tag;
   logic [63:0] rd2_data;
   logic        rd2_ready;
   logic        flush;
   logic [4:0]  commit_arf;
   logic [63:0] commit_result;
   logic [63:0] commit_pc;
   logic [12:0] commit_flags;
   logic        commit_valid;

   typedef struct {
      logic [4:0]  arf;
      logic [63:0] result;
      logic [63:0] pc;
      logic [12:0] flags;
   } exp_commit_t;

   exp_commit_t sb[$];
   int n_checks = 0;
   int n_fails  = 0;

   reorder_buffer #(.DEPTH(32), .TAG_BASE(32)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .do_alloc      (do_alloc),
      .alloc_arf     (alloc_arf),
      .alloc_pc      (alloc_pc),
      .next_free     (next_free),
      .is_free       (is_free),
      .wb_valid      (wb_valid),
      .wb_tag        (wb_tag),
      .wb_result     (wb_result),
      .wb_flags      (wb_flags),
      .rd1_tag       (rd1_tag),
      .rd1_data      (rd1_data),
      .rd1_ready     (rd1_ready),
      .rd2_tag       (rd2_tag),
      .rd2_data      (rd2_data),
      .rd2_ready     (rd2_ready),
      .flush         (flush),
      .commit_arf    (commit_arf),
      .commit_result (commit_result),
      .commit_pc     (commit_pc),
      .commit_flags  (commit_flags),
      .commit_valid  (commit_valid)
   );

   // 10 time-unit clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_output(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      do_alloc  = 1'b0;
      alloc_arf = '0;
      alloc_pc  = '0;
      wb_valid  = 1'b0;
      wb_tag    = '0;
      wb_result = '0;
      wb_flags  = '0;
      flush     = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset_n = 1'b0;
      #3;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic alloc(input logic [4:0] arf, input logic [63:0] pc);
      do_alloc  = 1'b1;
      alloc_arf = arf;
      alloc_pc  = pc;
      tick();
      do_alloc  = 1'b0;
   endtask

   task automatic writeback(input logic [7:0] tag, input logic [63:0] res,
                            input logic [12:0] flg);
      wb_valid  = 1'b1;
      wb_tag    = tag;
      wb_result = res;
      wb_flags  = flg;
      tick();
      wb_valid  = 1'b0;
   endtask

   task automatic expect_commit(input logic [4:0] arf, input logic [63:0] res,
                                input logic [63:0] pc, input logic [12:0] flg);
      exp_commit_t e;
      e.arf    = arf;
      e.result = res;
      e.pc     = pc;
      e.flags  = flg;
      sb.push_back(e);
   endtask

   // Scoreboard monitor: every presented commit must match the queue head.
   always @(negedge clock) begin
      if (reset_n && commit_valid) begin
         if (sb.size() == 0) begin
            check_output("unexpected_commit", 64'(commit_pc), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            exp_commit_t e;
            e = sb.pop_front();
            check_output("commit_arf",    64'(commit_arf),   64'(e.arf));
            check_output("commit_result", commit_result,    e.result);
            check_output("commit_pc",     commit_pc,         e.pc);
            check_output("commit_flags",  64'(commit_flags), 64'(e.flags));
         end
      end
   end

   initial begin
      rd1_tag = 8'd0;
      rd2_tag = 8'd0;

      // Reset state.
      idle_inputs();
      reset_n = 1'b0;
      #3;
      check_output("rst_is_free",      64'(is_free),       64'd1);
      check_output("rst_next_free",    64'(next_free),     64'd32);
      check_output("rst_commit_valid", 64'(commit_valid),  64'd0);
      check_output("rst_commit_res",   commit_result,      64'd0);
      check_output("rst_commit_arf",   64'(commit_arf),    64'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Single alloc, writeback, commit.
      alloc(5'd3, 64'h1000);
      check_output("t1_next_free", 64'(next_free), 64'd33);
      expect_commit(5'd3, 64'hDEAD, 64'h1000, 13'd0);
      writeback(8'd32, 64'hDEAD, 13'd0);
      check_output("t1_no_bypass", 64'(commit_valid), 64'd0);
      tick();
      check_output("t1_commit_valid", 64'(commit_valid), 64'd1);
      tick();
      check_output("t1_commit_drop", 64'(commit_valid), 64'd0);

      // Fill the buffer.
      do_reset();
      for (int i = 0; i < 32; i++) begin
         if (i == 31) check_output("t2_free_before_last", 64'(is_free), 64'd1);
         alloc(5'(i), 64'h2000 + 64'(i * 4));
      end
      check_output("t2_full",      64'(is_free),   64'd0);
      check_output("t2_next_wrap", 64'(next_free), 64'd32);
      alloc(5'd9, 64'h9999);
      check_output("t2_count_hold", 64'(dut.count_q), 64'd32);
      check_output("t2_tail_hold",  64'(dut.tail),    64'd0);

      // Full buffer, head done, alloc held across the commit edge.
      expect_commit(5'd0, 64'h4444, 64'h2000, 13'h5);
      writeback(8'd32, 64'h4444, 13'h5);
      check_output("t4_full_pre", 64'(is_free), 64'd0);
      do_alloc  = 1'b1;
      alloc_arf = 5'd7;
      alloc_pc  = 64'h3000;
      tick();
      check_output("t4_count_31",  64'(dut.count_q), 64'd31);
      check_output("t4_free",      64'(is_free),     64'd1);
      check_output("t4_next_free", 64'(next_free),   64'd32);
      tick();
      do_alloc = 1'b0;
      check_output("t4_count_32",  64'(dut.count_q), 64'd32);
      check_output("t4_full_post", 64'(is_free),     64'd0);
      rd1_tag = 8'd32;
      #1;
      check_output("t4_new_not_done", 64'(rd1_ready), 64'd0);

      // Ignored writebacks and out-of-range lookups.
      do_reset();
      alloc(5'd1, 64'h500);
      alloc(5'd2, 64'h504);
      writeback(8'd31, 64'hBAD, 13'd1);
      writeback(8'd64, 64'hBAD, 13'd1);
      writeback(8'd40, 64'hBAD, 13'd1);
      rd1_tag = 8'd40;
      rd2_tag = 8'd32;
      #1;
      check_output("t5_unalloc_ready", 64'(rd1_ready), 64'd0);
      check_output("t5_head_ready",    64'(rd2_ready), 64'd0);
      rd1_tag = 8'd64;
      #1;
      check_output("t5_oor_ready", 64'(rd1_ready), 64'd0);
      check_output("t5_oor_data",  rd1_data,       64'd0);
      check_output("t5_count",     64'(dut.count_q), 64'd2);
      check_output("t5_next_free", 64'(next_free),   64'd34);
      writeback(8'd33, 64'h3333, 13'd0);
      rd2_tag = 8'd33;
      #1;
      check_output("t5_rd2_ready", 64'(rd2_ready), 64'd1);
      check_output("t5_rd2_data",  rd2_data,       64'h3333);

      // Out-of-order writebacks retire in order.
      do_reset();
      alloc(5'd1, 64'h100);
      alloc(5'd2, 64'h104);
      alloc(5'd3, 64'h108);
      writeback(8'd34, 64'h99, 13'd0);
      writeback(8'd34, 64'h34, 13'h2);
      writeback(8'd33, 64'h33, 13'd0);
      expect_commit(5'd1, 64'h32, 64'h100, 13'd0);
      expect_commit(5'd2, 64'h33, 64'h104, 13'd0);
      expect_commit(5'd3, 64'h34, 64'h108, 13'h2);
      writeback(8'd32, 64'h32, 13'd0);
      check_output("t3_wait", 64'(commit_valid), 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_output("t3_commit_run", 64'(commit_valid), 64'd1);
      end
      tick();
      check_output("t3_commit_end", 64'(commit_valid), 64'd0);

      // Flush with simultaneous alloc and writeback.
      do_reset();
      for (int i = 0; i < 5; i++) alloc(5'(i + 10), 64'h700 + 64'(i * 4));
      writeback(8'd33, 64'h1, 13'd0);
      writeback(8'd34, 64'h2, 13'd0);
      flush     = 1'b1;
      do_alloc  = 1'b1;
      wb_valid  = 1'b1;
      wb_tag    = 8'd32;
      wb_result = 64'h77;
      tick();
      idle_inputs();
      check_output("t6_count",        64'(dut.count_q), 64'd0);
      check_output("t6_head",         64'(dut.head),    64'd0);
      check_output("t6_tail",         64'(dut.tail),    64'd0);
      check_output("t6_commit_valid", 64'(commit_valid), 64'd0);
      check_output("t6_next_free",    64'(next_free),   64'd32);
      for (int t = 32; t <= 36; t++) begin
         rd1_tag = 8'(t);
         rd2_tag = 8'(t);
         #1;
         check_output("t6_rd1_ready", 64'(rd1_ready), 64'd0);
         check_output("t6_rd2_ready", 64'(rd2_ready), 64'd0);
      end
      alloc(5'd4, 64'h800);
      check_output("t6_realloc", 64'(next_free), 64'd33);

      // Asynchronous reset in the middle of a cycle.
      #2;
      reset_n = 1'b0;
      #1;
      check_output("async_count",     64'(dut.count_q), 64'd0);
      check_output("async_next_free", 64'(next_free),   64'd32);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      tick();

      check_output("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
